// File: rtl/terrain_pkg.sv
// rtl/terrain_pkg.sv - shared sizes and crater sequencer state encoding
package terrain_pkg;
  localparam int NCOLS = 640;
  localparam int NROWS = 480;
  localparam int RW    = 6;

  typedef enum logic [2:0] {
    IDLE,
    CHORD,
    READ,
    WAIT,
    WRITE,
    DONE
  } crater_state_t;
endpackage

// File: rtl/crater_mask.sv
// rtl/crater_mask.sv - clears bits cy-h..cy+h of one column word, clamped to the word
module crater_mask
  import terrain_pkg::*;
(
  input  logic [NROWS-1:0] rdata,
  input  logic [9:0]       cy,
  input  logic [RW-1:0]    h,
  output logic [NROWS-1:0] wdata
);
  logic signed [11:0] lo;
  logic signed [11:0] hi;

  // Signed bounds make the clamp at 0 and at NROWS-1 fall out of the per-bit compare
  assign lo = $signed(12'(cy)) - $signed(12'(h));
  assign hi = $signed(12'(cy)) + $signed(12'(h));

  for (genvar i = 0; i < NROWS; i++) begin : g_bit
    localparam logic signed [11:0] IDX = 12'(i);
    assign wdata[i] = rdata[i] & ~((IDX >= lo) && (IDX <= hi));
  end
endmodule

// File: rtl/terrain_crater_ctrl.sv
// rtl/terrain_crater_ctrl.sv - read-modify-write sequencer carving circular craters into terrain SRAM
module terrain_crater_ctrl
  import terrain_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [9:0]       cx,
  input  logic [9:0]       cy,
  input  logic [RW-1:0]    radius,
  output logic             ack,
  output logic             busy,
  output logic             done,
  input  logic             gen_busy,
  input  logic             vid_active,
  input  logic [9:0]       vid_addr,
  output logic [9:0]       sram_raddr,
  input  logic [NROWS-1:0] sram_rdata,
  output logic             sram_we,
  output logic [9:0]       sram_waddr,
  output logic [NROWS-1:0] sram_wdata
);
  localparam logic [9:0]  NCOLS_W = 10'(NCOLS);
  localparam logic [10:0] COL_MAX = 11'(NCOLS - 1);

  crater_state_t    state_q, state_d;
  logic             ack_q, ack_d;
  logic [9:0]       cx_q, cx_d;
  logic [9:0]       cy_q, cy_d;
  logic [RW-1:0]    r_q, r_d;
  logic [9:0]       col_q, col_d;
  logic [9:0]       col_hi_q, col_hi_d;
  logic [RW-1:0]    h_q, h_d;
  logic             we_q, we_d;
  logic [9:0]       waddr_q, waddr_d;
  logic [NROWS-1:0] wdata_q, wdata_d;

  logic signed [10:0] lo_s;
  logic [10:0]        hi_sum;
  logic [9:0]         col_lo, col_hi;
  logic signed [10:0] dx;
  logic [10:0]        dx_mag;
  logic [12:0]        h_sq, dx_sq, r_sq;
  logic               shrink;
  logic [NROWS-1:0]   mask_word;

  crater_mask u_mask (
    .rdata (sram_rdata),
    .cy    (cy_q),
    .h     (h_q),
    .wdata (mask_word)
  );

  assign lo_s   = $signed({1'b0, cx}) - $signed(11'(radius));
  assign hi_sum = 11'(cx) + 11'(radius);
  assign col_lo = lo_s[10] ? 10'd0 : lo_s[9:0];
  assign col_hi = (hi_sum > COL_MAX) ? COL_MAX[9:0] : hi_sum[9:0];

  // Chord half-height shrinks one row per cycle until the edge point lies inside the circle
  assign dx     = $signed({1'b0, col_q}) - $signed({1'b0, cx_q});
  assign dx_mag = dx[10] ? 11'(-dx) : 11'(dx);
  assign h_sq   = 13'(h_q) * 13'(h_q);
  assign dx_sq  = 13'(dx_mag) * 13'(dx_mag);
  assign r_sq   = 13'(r_q) * 13'(r_q);
  assign shrink = (h_sq + dx_sq) > r_sq;

  assign sram_raddr = (vid_active || state_q != READ) ? vid_addr : col_q;
  assign ack        = ack_q;
  assign done       = (state_q == DONE);
  assign busy       = (state_q == CHORD) || (state_q == READ) ||
                      (state_q == WAIT)  || (state_q == WRITE);
  assign sram_we    = we_q;
  assign sram_waddr = waddr_q;
  assign sram_wdata = wdata_q;

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    cx_d     = cx_q;
    cy_d     = cy_q;
    r_d      = r_q;
    col_d    = col_q;
    col_hi_d = col_hi_q;
    h_d      = h_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (req && !gen_busy) begin
          ack_d    = 1'b1;
          cx_d     = cx;
          cy_d     = cy;
          r_d      = radius;
          col_d    = col_lo;
          col_hi_d = col_hi;
          h_d      = radius;
          state_d  = (cx >= NCOLS_W) ? DONE : CHORD;
        end
      end
      CHORD: begin
        if (shrink) h_d = h_q - 1'b1;
        else        state_d = READ;
      end
      READ: begin
        if (!vid_active) state_d = WAIT;
      end
      WAIT: begin
        wdata_d = mask_word;
        waddr_d = col_q;
        we_d    = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        if (col_q == col_hi_q) begin
          state_d = DONE;
        end else begin
          col_d   = col_q + 1'b1;
          h_d     = r_q;
          state_d = CHORD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
      r_q      <= '0;
      col_q    <= '0;
      col_hi_q <= '0;
      h_q      <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      r_q      <= r_d;
      col_q    <= col_d;
      col_hi_q <= col_hi_d;
      h_q      <= h_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end
endmodule

// File: tb/tb_terrain_crater_ctrl.sv
// tb/tb_terrain_crater_ctrl.sv - directed self-checking bench for terrain_crater_ctrl
module tb_terrain_crater_ctrl;
  import terrain_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req = 1'b0;
  logic [9:0]       cx_i = '0;
  logic [9:0]       cy_i = '0;
  logic [RW-1:0]    radius_i = '0;
  logic             ack, busy, done;
  logic             gen_busy = 1'b0;
  logic             vid_active = 1'b0;
  logic [9:0]       vid_addr = 10'd0;
  logic [9:0]       sram_raddr;
  logic [NROWS-1:0] sram_rdata;
  logic             sram_we;
  logic [9:0]       sram_waddr;
  logic [NROWS-1:0] sram_wdata;

  logic             fill = 1'b0;
  logic [NROWS-1:0] mem [NCOLS];
  int               wr_cnt = 0;
  int               done_cnt = 0;
  int               bad_addr_cnt = 0;
  int               n_cmp = 0;
  int               n_err = 0;

  always #5 clk = ~clk;

  terrain_crater_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .cx         (cx_i),
    .cy         (cy_i),
    .radius     (radius_i),
    .ack        (ack),
    .busy       (busy),
    .done       (done),
    .gen_busy   (gen_busy),
    .vid_active (vid_active),
    .vid_addr   (vid_addr),
    .sram_raddr (sram_raddr),
    .sram_rdata (sram_rdata),
    .sram_we    (sram_we),
    .sram_waddr (sram_waddr),
    .sram_wdata (sram_wdata)
  );

  // Behavioural SRAM: registered read, write logged and counted
  always @(posedge clk) begin
    if (sram_raddr < 10'(NCOLS)) sram_rdata <= mem[sram_raddr];
    else                         sram_rdata <= '0;
    if (sram_we) wr_cnt <= wr_cnt + 1;
    if (done)    done_cnt <= done_cnt + 1;
    if (fill) begin
      for (int i = 0; i < NCOLS; i++) mem[i] <= '1;
    end else if (sram_we) begin
      if (sram_waddr < 10'(NCOLS)) mem[sram_waddr] <= sram_wdata;
      else                         bad_addr_cnt <= bad_addr_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic check_col(input string tag, input int col, input int lo, input int hi);
    logic [NROWS-1:0] e;
    e = '1;
    for (int i = lo; i <= hi; i++) e[i] = 1'b0;
    check_eq(tag, 512'(mem[col]), 512'(e));
  endtask

  task automatic fill_all;
    fill = 1'b1;
    @(posedge clk); #1;
    fill = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic start_req(input int x, input int y, input int r);
    int ok;
    cx_i = 10'(x); cy_i = 10'(y); radius_i = RW'(r);
    req = 1'b1;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (ack) begin ok = 1; break; end
    end
    req = 1'b0;
    check_eq("ack_seen", 512'(ok), 512'(1));
  endtask

  task automatic wait_done(output int cyc);
    int ok;
    ok = 0; cyc = 0;
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin ok = 1; break; end
    end
    check_eq("done_seen", 512'(ok), 512'(1));
    @(posedge clk); #1;
    check_eq("done_one_cycle", 512'(done), 512'(0));
    check_eq("busy_after_done", 512'(busy), 512'(0));
  endtask

  initial begin
    int cyc, w0, d0, stall_bad, acks;
    #3;
    check_eq("rst_ack", 512'(ack), 512'(0));
    check_eq("rst_busy", 512'(busy), 512'(0));
    check_eq("rst_done", 512'(done), 512'(0));
    check_eq("rst_we", 512'(sram_we), 512'(0));
    check_eq("rst_waddr", 512'(sram_waddr), 512'(0));
    check_eq("rst_wdata", 512'(sram_wdata), 512'(0));
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    fill_all();

    // Basic crater r=2 at (100,300)
    w0 = wr_cnt; d0 = done_cnt;
    start_req(100, 300, 2);
    check_eq("t1_busy_at_ack", 512'(busy), 512'(1));
    wait_done(cyc);
    check_eq("t1_writes", 512'(wr_cnt - w0), 512'(5));
    check_eq("t1_dones", 512'(done_cnt - d0), 512'(1));
    check_col("t1_c97", 97, 1, 0);
    check_col("t1_c98", 98, 300, 300);
    check_col("t1_c99", 99, 299, 301);
    check_col("t1_c100", 100, 298, 302);
    check_col("t1_c101", 101, 299, 301);
    check_col("t1_c102", 102, 300, 300);
    check_col("t1_c103", 103, 1, 0);

    // Left-edge clamp, then bottom-row clamp
    fill_all();
    w0 = wr_cnt;
    start_req(0, 5, 3);
    wait_done(cyc);
    check_eq("t2_writes", 512'(wr_cnt - w0), 512'(4));
    check_eq("t2_bad_addr", 512'(bad_addr_cnt), 512'(0));
    check_col("t2_c0", 0, 2, 8);
    check_col("t2_c1", 1, 3, 7);
    check_col("t2_c2", 2, 3, 7);
    check_col("t2_c3", 3, 5, 5);
    check_col("t2_c4", 4, 1, 0);
    check_col("t2_c639", 639, 1, 0);
    w0 = wr_cnt;
    start_req(300, 478, 4);
    wait_done(cyc);
    check_eq("t2b_writes", 512'(wr_cnt - w0), 512'(9));
    check_col("t2b_c300", 300, 474, 479);
    check_col("t2b_c296", 296, 478, 478);
    check_col("t2b_c304", 304, 478, 478);

    // Renderer holds the read port
    fill_all();
    vid_active = 1'b1; vid_addr = 10'd555;
    w0 = wr_cnt;
    start_req(200, 100, 2);
    stall_bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (sram_raddr !== 10'd555 || sram_we !== 1'b0) stall_bad++;
    end
    check_eq("t3_stall_port", 512'(stall_bad), 512'(0));
    check_eq("t3_stall_writes", 512'(wr_cnt - w0), 512'(0));
    check_eq("t3_stall_busy", 512'(busy), 512'(1));
    vid_active = 1'b0;
    wait_done(cyc);
    check_eq("t3_writes", 512'(wr_cnt - w0), 512'(5));
    check_col("t3_c198", 198, 100, 100);
    check_col("t3_c199", 199, 99, 101);
    check_col("t3_c200", 200, 98, 102);
    check_col("t3_c201", 201, 99, 101);
    check_col("t3_c202", 202, 100, 100);

    // Generator regeneration blocks acceptance
    fill_all();
    gen_busy = 1'b1;
    cx_i = 10'd400; cy_i = 10'd50; radius_i = RW'(1);
    req = 1'b1;
    acks = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    check_eq("t4_no_ack", 512'(acks), 512'(0));
    check_eq("t4_idle_busy", 512'(busy), 512'(0));
    gen_busy = 1'b0;
    @(posedge clk); #1;
    check_eq("t4_ack", 512'(ack), 512'(1));
    check_eq("t4_busy", 512'(busy), 512'(1));
    req = 1'b0;
    wait_done(cyc);
    check_col("t4_c400", 400, 49, 51);
    check_col("t4_c399", 399, 50, 50);

    // Zero radius: single bit, fixed latency
    fill_all();
    w0 = wr_cnt;
    start_req(10, 10, 0);
    wait_done(cyc);
    check_eq("t5_latency", 512'(cyc), 512'(4));
    check_eq("t5_writes", 512'(wr_cnt - w0), 512'(1));
    check_col("t5_c10", 10, 10, 10);
    check_col("t5_c11", 11, 1, 0);

    // Reset while in WAIT abandons the crater
    w0 = wr_cnt;
    start_req(30, 30, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("t6_pre_waddr", 512'(sram_waddr), 512'(10));
    reset = 1'b1;
    #1;
    check_eq("t6_ack", 512'(ack), 512'(0));
    check_eq("t6_busy", 512'(busy), 512'(0));
    check_eq("t6_done", 512'(done), 512'(0));
    check_eq("t6_we", 512'(sram_we), 512'(0));
    check_eq("t6_waddr", 512'(sram_waddr), 512'(0));
    check_eq("t6_wdata", 512'(sram_wdata), 512'(0));
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
    end
    check_eq("t6_no_write", 512'(wr_cnt - w0), 512'(0));
    check_col("t6_c30", 30, 1, 0);
    start_req(20, 20, 0);
    wait_done(cyc);
    check_eq("t6_new_writes", 512'(wr_cnt - w0), 512'(1));
    check_col("t6_c20", 20, 20, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
